// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive checker: glyph codes
// (active-low, bit order {g,f,e,d,c,b,a}), blank code, and FSM states.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;

  localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble decoder; anything outside the 16 hex
// glyphs (blank included) raises illegal and returns nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] glyph,
  output logic [NIB_W-1:0] nibble,
  output logic             illegal
);

  // Table lookup; default arm catches every non-hex code.
  always_comb begin
    nibble  = '0;
    illegal = 1'b0;
    case (glyph)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_display_decoder.sv
// Four-digit seven-segment receive checker: debounces the bus, decodes
// accepted patterns, flags illegal glyphs and counts updates.
// Optional: define SEG7_DECODER_STEP_CHECK_EN to enable the +1 step monitor
// (otherwise step_error is tied low).
module seg7_display_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [6:0]   seven_segment_0,
  input  logic [6:0]   seven_segment_1,
  input  logic [6:0]   seven_segment_2,
  input  logic [6:0]   seven_segment_3,
  output logic [15:0]  value,
  output logic         value_valid,
  output logic [3:0]   digit_error,
  output logic         update,
  output logic         step_error,
  output logic [15:0]  update_count
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0][SEG_W-1:0] bus, sample_q, held_q;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] nib, value_q, value_d;
  logic [NUM_DIGITS-1:0]            ill;
  logic [7:0]                       stab_q, stab_d;
  logic                             accept, legal, step_fail;
  state_t                           state_q, state_d;

  assign bus   = {seven_segment_3, seven_segment_2, seven_segment_1, seven_segment_0};
  assign value = value_q;
  assign legal = ~|ill;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      seg7_glyph_decode u_dec (
        .glyph   (bus[gi]),
        .nibble  (nib[gi]),
        .illegal (ill[gi])
      );
      // Illegal digits keep their previous nibble.
      assign value_d[gi] = ill[gi] ? value_q[gi] : nib[gi];
    end
  endgenerate

  // Stability count: restart on any change, saturate at the window length.
  always_comb begin
    stab_d = stab_q;
    if (bus != sample_q)       stab_d = 8'd1;
    else if (stab_q < STABLE_N) stab_d = stab_q + 8'd1;
  end

  // Accept only a newly stable pattern that differs from what is held.
  assign accept = (stab_d == STABLE_N) && (bus != held_q);

`ifdef SEG7_DECODER_STEP_CHECK_EN
  // Step rule: from LOCKED, a legal accept must be old+1 (wrapping) or 0.
  always_comb begin
    step_fail = 1'b0;
    if (state_q == LOCKED && legal)
      step_fail = !((value_d == 16'(value_q + 16'd1)) || (value_d == 16'd0));
  end
`else
  assign step_fail = 1'b0;
`endif

  // FSM next state: move only on an accept.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = legal ? LOCKED : FAULT;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Sample/hold registers, decoded outputs and update bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q     <= {NUM_DIGITS{GLYPH_BLANK}};
      held_q       <= {NUM_DIGITS{GLYPH_BLANK}};
      stab_q       <= '0;
      value_q      <= '0;
      value_valid  <= 1'b0;
      digit_error  <= '0;
      update       <= 1'b0;
      step_error   <= 1'b0;
      update_count <= '0;
    end else begin
      sample_q   <= bus;
      stab_q     <= stab_d;
      update     <= 1'b0;
      step_error <= 1'b0;
      if (accept) begin
        held_q      <= bus;
        value_q     <= value_d;
        value_valid <= legal;
        digit_error <= ill;
        update      <= 1'b1;
        step_error  <= step_fail;
        if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_decoder.sv
// Directed bench for seg7_display_decoder with a behavioural model feeding an
// expected-update queue; a negedge monitor pops and compares on each update.
module tb_seg7_display_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] GLY [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [27:0] BLANK_BUS = 28'hFFFFFFF;

  typedef struct {
    logic [15:0] v;
    logic        vv;
    logic [3:0]  de;
    logic        se;
    logic [15:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_error;
  logic        update;
  logic        step_error;
  logic [15:0] update_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  exp_t        mon_e;

  // model state: 0 empty, 1 locked, 2 fault
  logic [15:0] mvalue = '0;
  int          mstate = 0;
  logic [15:0] mcount = '0;
  logic [27:0] mheld  = BLANK_BUS;

  seg7_display_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clock           (clock),
    .reset           (reset),
    .seven_segment_0 (seg0),
    .seven_segment_1 (seg1),
    .seven_segment_2 (seg2),
    .seven_segment_3 (seg3),
    .value           (value),
    .value_valid     (value_valid),
    .digit_error     (digit_error),
    .update          (update),
    .step_error      (step_error),
    .update_count    (update_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp_v);
    end
  endtask

  function automatic logic [27:0] pat(input logic [15:0] h);
    logic [27:0] p;
    logic [3:0]  n;
    for (int i = 0; i < 4; i++) begin
      n = h[i*4 +: 4];
      p[i*7 +: 7] = GLY[n];
    end
    return p;
  endfunction

  task automatic model_reset();
    mvalue = '0; mstate = 0; mcount = '0; mheld = BLANK_BUS;
    q.delete();
  endtask

  task automatic expect_accept(input logic [27:0] b);
    exp_t        e;
    logic [15:0] nv;
    logic [3:0]  il;
    logic [6:0]  code;
    bit          found;
    nv = mvalue;
    il = '0;
    for (int d = 0; d < 4; d++) begin
      code  = b[d*7 +: 7];
      found = 0;
      for (int k = 0; k < 16; k++)
        if (GLY[k] == code) begin
          found = 1;
          nv[d*4 +: 4] = 4'(k);
        end
      if (!found) il[d] = 1'b1;
    end
    e.se = 1'b0;
    if (il == 4'b0) begin
`ifdef SEG7_DECODER_STEP_CHECK_EN
      if (mstate == 1 && !(nv == 16'(mvalue + 16'd1) || nv == 16'd0)) e.se = 1'b1;
`endif
      mstate = 1;
    end else begin
      mstate = 2;
    end
    mvalue = nv;
    if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
    e.v = nv; e.vv = (il == 4'b0); e.de = il; e.cnt = mcount;
    q.push_back(e);
  endtask

  // Drive a bus pattern at a negedge and hold it for 'hold' cycles.
  task automatic show(input logic [27:0] b, input int hold);
    if (b != mheld && hold >= STABLE) begin
      expect_accept(b);
      mheld = b;
    end
    {seg3, seg2, seg1, seg0} = b;
    repeat (hold) @(negedge clock);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_value"}, 32'(value), 32'h0);
    chk({tag, "_valid"}, 32'(value_valid), 32'h0);
    chk({tag, "_derr"},  32'(digit_error), 32'h0);
    chk({tag, "_update"}, 32'(update), 32'h0);
    chk({tag, "_step"},  32'(step_error), 32'h0);
    chk({tag, "_count"}, 32'(update_count), 32'h0);
  endtask

  // Scoreboard: every update must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset && update) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_update got value %h expected no update", value);
      end
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("upd_value", 32'(value), 32'(mon_e.v));
        chk("upd_valid", 32'(value_valid), 32'(mon_e.vv));
        chk("upd_derr",  32'(digit_error), 32'(mon_e.de));
        chk("upd_step",  32'(step_error), 32'(mon_e.se));
        chk("upd_count", 32'(update_count), 32'(mon_e.cnt));
      end
    end
    if (!reset && step_error && !update) chk("step_without_update", 32'(step_error), 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] b;
    {seg3, seg2, seg1, seg0} = BLANK_BUS;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset_check("rst");
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("blank_no_accept", 32'(update_count), 32'h0);

    // first accept from EMPTY, then a clean +1 run
    show(pat(16'h0000), 10);
    for (int h = 1; h <= 16; h++) show(pat(16'(h)), 10);
    chk("run_count", 32'(update_count), 32'd17);
    chk("run_value", 32'(value), 32'h0010);

    // step violations and the zero escape
    show(pat(16'h0005), 10);
    show(pat(16'h0007), 10);
    show(pat(16'h0000), 10);

    // short glitch on digit 0 is invisible
    b = pat(16'h0000);
    b[6:0] = GLY[1];
    show(b, STABLE - 1);
    show(pat(16'h0000), 10);
    chk("glitch_count", 32'(update_count), 32'(mcount));
    chk("glitch_queue", 32'(q.size()), 32'h0);

    // illegal glyphs keep old nibbles, then recover without a step check
    b = pat(16'h1234);
    b[20:14] = 7'b1111111;
    show(b, 10);
    chk("blank_derr", 32'(digit_error), 32'h4);
    chk("blank_valid", 32'(value_valid), 32'h0);
    b = pat(16'h5678);
    b[6:0] = 7'h55;
    show(b, 10);
    show(pat(16'h1234), 10);
    chk("recover_valid", 32'(value_valid), 32'h1);

    // reset in the middle of a stability window
    {seg3, seg2, seg1, seg0} = pat(16'hFFFF);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    reset_check("rst_window");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    show(pat(16'hFFFF), 10);
    show(pat(16'h0000), 10);

    // reset while the update pulse for FFFF is high
    {seg3, seg2, seg1, seg0} = pat(16'hFFFF);
    repeat (STABLE) @(posedge clock);
    #1;
    chk("pulse_update", 32'(update), 32'h1);
    chk("pulse_value", 32'(value), 32'hFFFF);
    reset = 1'b1;
    #1;
    reset_check("rst_pulse");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    show(pat(16'hFFFF), 10);
    show(pat(16'h0000), 10);

    repeat (5) @(negedge clock);
    chk("final_queue", 32'(q.size()), 32'h0);
    chk("final_count", 32'(update_count), 32'(mcount));
    chk("final_value", 32'(value), 32'(mvalue));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
